// File: rtl/ov5640_init_seq.sv
// OV5640 init sequencer: walks the register ROM and issues one SCCB write per entry,
// with power-up wait, post-soft-reset delay and bounded NACK retries.
module ov5640_init_seq #(
    parameter int DATA_WIDTH     = 24,
    parameter int ADDR_WIDTH     = 8,
    parameter int TABLE_LEN      = 252,
    parameter int PWRUP_CYCLES   = 1_000_000,
    parameter int RST_DLY_CYCLES = 250_000,
    parameter int RST_IDX        = 1,
    parameter int MAX_RETRY      = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic                  wr_req,
    output logic [15:0]           wr_addr,
    output logic [7:0]            wr_data,
    input  logic                  wr_done,
    input  logic                  wr_err,
    output logic [ADDR_WIDTH-1:0] cfg_index,
    output logic                  init_done,
    output logic                  init_err
);

    // One shared wait counter serves both the power-up and the soft-reset delay.
    localparam int CNT_MAX = (PWRUP_CYCLES > RST_DLY_CYCLES) ? PWRUP_CYCLES : RST_DLY_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0]      PWRUP_LAST = CNT_W'(PWRUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]      DLY_LAST   = CNT_W'(RST_DLY_CYCLES - 1);
    localparam logic [RTY_W-1:0]      RTY_LAST   = RTY_W'(MAX_RETRY);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(TABLE_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] SRST_IDX   = ADDR_WIDTH'(RST_IDX);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_FETCH,
        S_ROMWAIT,
        S_REQ,
        S_GAP,
        S_DELAY,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [RTY_W-1:0]        r_retry;
    logic [ADDR_WIDTH-1:0]   r_cfg_index;
    logic                    r_wr_req;
    logic [15:0]             r_wr_addr;
    logic [7:0]              r_wr_data;
    logic                    r_init_done;
    logic                    r_init_err;

    logic [15:0]             w_rom_reg;
    logic [7:0]              w_rom_val;

    assign w_rom_reg = rom_q[23:8];
    assign w_rom_val = rom_q[7:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_PWRUP;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_cfg_index <= '0;
            r_wr_req    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_init_done <= 1'b0;
            r_init_err  <= 1'b0;
        end else begin
            case (r_state)
                S_PWRUP: begin
                    if (r_cnt == PWRUP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_FETCH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FETCH: begin
                    r_state <= S_ROMWAIT;
                end
                S_ROMWAIT: begin
                    r_wr_addr <= w_rom_reg;
                    r_wr_data <= w_rom_val;
                    r_wr_req  <= 1'b1;
                    r_state   <= S_REQ;
                end
                S_REQ: begin
                    if (wr_done) begin
                        r_wr_req <= 1'b0;
                        if (wr_err) begin
                            if (r_retry == RTY_LAST) begin
                                r_init_err <= 1'b1;
                                r_state    <= S_ERROR;
                            end else begin
                                r_retry <= r_retry + 1'b1;
                                r_state <= S_GAP;
                            end
                        end else begin
                            r_retry <= '0;
                            // The soft-reset entry is checked first so a trailing reset still gets its delay.
                            if (r_cfg_index == SRST_IDX) begin
                                r_cnt   <= '0;
                                r_state <= S_DELAY;
                            end else if (r_cfg_index == LAST_IDX) begin
                                r_init_done <= 1'b1;
                                r_state     <= S_DONE;
                            end else begin
                                r_cfg_index <= r_cfg_index + 1'b1;
                                r_state     <= S_FETCH;
                            end
                        end
                    end
                end
                S_GAP: begin
                    r_wr_req <= 1'b1;
                    r_state  <= S_REQ;
                end
                S_DELAY: begin
                    if (r_cnt == DLY_LAST) begin
                        r_cnt <= '0;
                        if (r_cfg_index == LAST_IDX) begin
                            r_init_done <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_cfg_index <= r_cfg_index + 1'b1;
                            r_state     <= S_FETCH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE, S_ERROR: begin
                    if (start) begin
                        r_init_done <= 1'b0;
                        r_init_err  <= 1'b0;
                        r_cfg_index <= '0;
                        r_retry     <= '0;
                        r_state     <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_PWRUP;
                end
            endcase
        end
    end

    assign rom_addr  = r_cfg_index;
    assign cfg_index = r_cfg_index;
    assign wr_req    = r_wr_req;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign init_done = r_init_done;
    assign init_err  = r_init_err;

endmodule

// File: tb/tb_ov5640_init_seq.sv
// Directed bench for ov5640_init_seq: stub registered ROM plus an SCCB model that
// acks (or NACKs on demand) on the 10th cycle of each request.
module tb_ov5640_init_seq;

    localparam int AW = 8;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q;
    logic          wr_req;
    logic [15:0]   wr_addr;
    logic [7:0]    wr_data;
    logic          wr_done;
    logic          wr_err;
    logic [AW-1:0] cfg_index;
    logic          init_done;
    logic          init_err;

    ov5640_init_seq #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TABLE_LEN     (8),
        .PWRUP_CYCLES  (100),
        .RST_DLY_CYCLES(50),
        .RST_IDX       (1),
        .MAX_RETRY     (3)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_done  (wr_done),
        .wr_err   (wr_err),
        .cfg_index(cfg_index),
        .init_done(init_done),
        .init_err (init_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] rom [0:255];
    always @(posedge clk) rom_q <= rom[rom_addr];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          nack_idx = -1;
    int          nack_left = 0;
    int          ack_cnt;
    int          stab_err;
    int          idone_cyc;
    logic        prev_req;
    logic        prev_idone;
    logic [15:0] hold_addr;
    logic [7:0]  hold_data;
    int          req_cyc[$];
    int          done_cyc[$];
    int          req_idx[$];
    logic [15:0] req_addr[$];
    logic [7:0]  req_data[$];

    // SCCB model and request logger, both working on the falling edge.
    initial begin
        wr_done = 1'b0; wr_err = 1'b0; ack_cnt = 0; stab_err = 0;
        prev_req = 1'b0; prev_idone = 1'b0; idone_cyc = -1;
        hold_addr = '0; hold_data = '0;
        forever begin
            @(negedge clk);
            wr_done = 1'b0;
            wr_err  = 1'b0;
            if (wr_req && !prev_req) begin
                req_cyc.push_back(cyc);
                req_addr.push_back(wr_addr);
                req_data.push_back(wr_data);
                req_idx.push_back(int'(cfg_index));
                hold_addr = wr_addr;
                hold_data = wr_data;
            end else if (wr_req && (wr_addr !== hold_addr || wr_data !== hold_data)) begin
                stab_err++;
            end
            prev_req = wr_req;
            if (init_done && !prev_idone) idone_cyc = cyc;
            prev_idone = init_done;
            if (wr_req) begin
                ack_cnt++;
                if (ack_cnt == 10) begin
                    ack_cnt = 0;
                    wr_done = 1'b1;
                    done_cyc.push_back(cyc);
                    if (int'(cfg_index) == nack_idx && nack_left > 0) begin
                        wr_err = 1'b1;
                        nack_left--;
                    end
                end
            end else begin
                ack_cnt = 0;
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        req_cyc.delete(); done_cyc.delete(); req_idx.delete();
        req_addr.delete(); req_data.delete();
        stab_err = 0; idone_cyc = -1;
    endtask

    task automatic wait_end(input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (init_done || init_err) begin
                to = 1'b0;
                break;
            end
        end
        tick(2);
    endtask

    task automatic wait_reqs(input int n, input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (req_cyc.size() >= n && wr_req) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_dones(input int n, input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (done_cyc.size() >= n) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic pulse_start(output int s);
        s = cyc;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    int rst_cyc;

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        tick(3);
        n_tests++;
        if ({wr_req, init_done, init_err, wr_addr, wr_data, cfg_index, rom_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {wr_req, init_done, init_err, wr_addr, wr_data, cfg_index, rom_addr});
        end
        clear_log();
        rst_cyc = cyc;
        reset_n = 1'b1;
        tick(60);
        n_tests++;
        if (wr_req !== 1'b0 || req_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL pwrup_hold: got wr_req=%b reqs=%0d expected 0/0", wr_req, req_cyc.size());
        end
    endtask

    task automatic test_sequence();
        bit to;
        wait_end(2000, to);
        n_tests++;
        if (to || init_done !== 1'b1 || init_err !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_complete: got to=%0d done=%b err=%b expected 0/1/0", to, init_done, init_err);
        end
        n_tests++;
        if (req_cyc.size() != 8 || done_cyc.size() != 8) begin
            n_fail++;
            $display("FAIL seq_count: got reqs=%0d dones=%0d expected 8/8", req_cyc.size(), done_cyc.size());
        end
        n_tests++;
        if (req_cyc.size() < 1 || req_cyc[0] != rst_cyc + 102) begin
            n_fail++;
            $display("FAIL seq_first_req: got %0d expected %0d",
                     (req_cyc.size() > 0) ? req_cyc[0] - rst_cyc : -1, 102);
        end
        for (int i = 0; i < req_addr.size() && i < 8; i++) begin
            n_tests++;
            if (req_addr[i] !== rom[i][23:8] || req_data[i] !== rom[i][7:0] || req_idx[i] != i) begin
                n_fail++;
                $display("FAIL seq_entry%0d: got %h/%h idx %0d expected %h/%h idx %0d",
                         i, req_addr[i], req_data[i], req_idx[i], rom[i][23:8], rom[i][7:0], i);
            end
        end
        n_tests++;
        if (stab_err != 0) begin
            n_fail++;
            $display("FAIL seq_stable: got %0d changes expected 0", stab_err);
        end
        n_tests++;
        if (done_cyc.size() < 8 || idone_cyc != done_cyc[7] + 1) begin
            n_fail++;
            $display("FAIL seq_done_lat: got %0d expected %0d", idone_cyc,
                     (done_cyc.size() >= 8) ? done_cyc[7] + 1 : -1);
        end
        for (int k = 0; k < 7 && k + 1 < req_cyc.size() && k < done_cyc.size(); k++) begin
            n_tests++;
            if (req_cyc[k+1] - done_cyc[k] != ((k == 1) ? 53 : 3)) begin
                n_fail++;
                $display("FAIL seq_gap%0d: got %0d expected %0d", k, req_cyc[k+1] - done_cyc[k],
                         (k == 1) ? 53 : 3);
            end
        end
    endtask

    task automatic test_restart();
        bit to;
        int s;
        logic [AW-1:0] idx_before;
        clear_log();
        pulse_start(s);
        n_tests++;
        if (init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_clear: got init_done=%b expected 0", init_done);
        end
        wait_reqs(3, 500, to);
        idx_before = cfg_index;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        n_tests++;
        if (to || cfg_index !== idx_before || wr_req !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_midreq: got to=%0d idx=%0d req=%b expected 0/%0d/1",
                     to, cfg_index, wr_req, idx_before);
        end
        wait_end(2000, to);
        n_tests++;
        if (to || init_done !== 1'b1 || req_cyc.size() != 8) begin
            n_fail++;
            $display("FAIL restart_pass: got to=%0d done=%b reqs=%0d expected 0/1/8",
                     to, init_done, req_cyc.size());
        end
        n_tests++;
        if (req_cyc.size() < 1 || req_cyc[0] != s + 3) begin
            n_fail++;
            $display("FAIL restart_nopwrup: got %0d expected 3",
                     (req_cyc.size() > 0) ? req_cyc[0] - s : -1);
        end
        for (int i = 0; i < req_idx.size() && i < 8; i++) begin
            n_tests++;
            if (req_idx[i] != i || req_addr[i] !== rom[i][23:8]) begin
                n_fail++;
                $display("FAIL restart_entry%0d: got idx %0d addr %h expected %0d %h",
                         i, req_idx[i], req_addr[i], i, rom[i][23:8]);
            end
        end
    endtask

    task automatic test_nack_retry();
        bit to;
        int s;
        int exp_idx[10] = '{0, 1, 2, 3, 4, 4, 4, 5, 6, 7};
        clear_log();
        nack_idx  = 4;
        nack_left = 2;
        pulse_start(s);
        wait_end(3000, to);
        n_tests++;
        if (to || init_done !== 1'b1 || init_err !== 1'b0 || req_cyc.size() != 10) begin
            n_fail++;
            $display("FAIL retry_complete: got to=%0d done=%b err=%b reqs=%0d expected 0/1/0/10",
                     to, init_done, init_err, req_cyc.size());
        end
        for (int i = 0; i < req_idx.size() && i < 10; i++) begin
            n_tests++;
            if (req_idx[i] != exp_idx[i] || req_addr[i] !== rom[exp_idx[i]][23:8]) begin
                n_fail++;
                $display("FAIL retry_req%0d: got idx %0d addr %h expected %0d %h",
                         i, req_idx[i], req_addr[i], exp_idx[i], rom[exp_idx[i]][23:8]);
            end
        end
        n_tests++;
        if (req_cyc.size() < 6 || done_cyc.size() < 5 || req_cyc[5] - done_cyc[4] != 2) begin
            n_fail++;
            $display("FAIL retry_gap: got %0d expected 2",
                     (req_cyc.size() >= 6 && done_cyc.size() >= 5) ? req_cyc[5] - done_cyc[4] : -1);
        end
    endtask

    task automatic test_nack_abort();
        bit to;
        int s;
        clear_log();
        nack_idx  = 4;
        nack_left = 4;
        pulse_start(s);
        wait_end(3000, to);
        n_tests++;
        if (to || init_err !== 1'b1 || init_done !== 1'b0 || cfg_index !== 8'd4) begin
            n_fail++;
            $display("FAIL abort_flags: got to=%0d err=%b done=%b idx=%0d expected 0/1/0/4",
                     to, init_err, init_done, cfg_index);
        end
        n_tests++;
        if (req_cyc.size() != 8 || nack_left != 0) begin
            n_fail++;
            $display("FAIL abort_attempts: got reqs=%0d nacks_left=%0d expected 8/0",
                     req_cyc.size(), nack_left);
        end
        tick(40);
        n_tests++;
        if (req_cyc.size() != 8 || wr_req !== 1'b0 || init_err !== 1'b1 || cfg_index !== 8'd4) begin
            n_fail++;
            $display("FAIL abort_quiet: got reqs=%0d req=%b err=%b idx=%0d expected 8/0/1/4",
                     req_cyc.size(), wr_req, init_err, cfg_index);
        end
        nack_idx = -1;
    endtask

    task automatic test_reset_mid();
        bit to;
        int s;
        clear_log();
        pulse_start(s);
        wait_dones(2, 500, to);
        tick(10);
        n_tests++;
        if (to || cfg_index !== 8'd1 || wr_req !== 1'b0 || init_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_in_delay: got to=%0d idx=%0d req=%b err=%b expected 0/1/0/0",
                     to, cfg_index, wr_req, init_err);
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({wr_req, init_done, init_err, wr_addr, wr_data, cfg_index, rom_addr} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_delay_async: got %h expected 0",
                     {wr_req, init_done, init_err, wr_addr, wr_data, cfg_index, rom_addr});
        end
        tick(2);
        clear_log();
        rst_cyc = cyc;
        reset_n = 1'b1;
        wait_reqs(1, 300, to);
        n_tests++;
        if (to || req_cyc[0] != rst_cyc + 102 || req_idx[0] != 0) begin
            n_fail++;
            $display("FAIL rstmid_pwrup: got to=%0d lat=%0d idx=%0d expected 0/102/0", to,
                     (req_cyc.size() > 0) ? req_cyc[0] - rst_cyc : -1,
                     (req_idx.size() > 0) ? req_idx[0] : -1);
        end
        wait_reqs(3, 300, to);
        tick(2);
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (to || {wr_req, init_done, init_err, wr_addr, wr_data, cfg_index, rom_addr} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_req_async: got to=%0d outs=%h expected 0/0", to,
                     {wr_req, init_done, init_err, wr_addr, wr_data, cfg_index, rom_addr});
        end
        tick(2);
        clear_log();
        rst_cyc = cyc;
        reset_n = 1'b1;
        wait_end(2000, to);
        n_tests++;
        if (to || init_done !== 1'b1 || req_cyc.size() != 8 || req_cyc[0] != rst_cyc + 102) begin
            n_fail++;
            $display("FAIL rstmid_rerun: got to=%0d done=%b reqs=%0d expected 0/1/8", to,
                     init_done, req_cyc.size());
        end
        for (int i = 0; i < req_idx.size() && i < 8; i++) begin
            n_tests++;
            if (req_idx[i] != i || req_data[i] !== rom[i][7:0]) begin
                n_fail++;
                $display("FAIL rstmid_entry%0d: got idx %0d data %h expected %0d %h",
                         i, req_idx[i], req_data[i], i, rom[i][7:0]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = {16'h3000 + 16'(i * 257), 8'(i * 13 + 1)};
        rom[1] = {16'h3008, 8'h82};
        reset_n = 1'b0;
        start   = 1'b0;
        test_reset();
        test_sequence();
        test_restart();
        test_nack_retry();
        test_nack_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
